fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of write requesters, range 2..8.
REQ-002 Parameter WIDTH, default 8: data width, equal to the shared sync FIFO WIDTH.
REQ-003 Parameter MAX_BURST, default 4: maximum consecutive writes per grant tenure, range 1..15.
REQ-004 clk  input  1: single clock, all state updates on posedge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 req  input  NREQ: per-requester write request, level-held while data is valid.
REQ-007 req_data  input  NREQ*WIDTH: packed data; slice i is bits [i*WIDTH +: WIDTH].
REQ-008 gnt  output  NREQ: one-hot accept strobe; gnt[i]=1 means req_data slice i is written this cycle.
REQ-009 fifo_full  input  1: full flag from the shared FIFO.
REQ-010 fifo_w_en  output  1: FIFO write enable.
REQ-011 fifo_data_in  output  WIDTH: FIFO write data.
REQ-012 owner_id  output  $clog2(NREQ): index of the current tenure owner, valid in GRANT.
REQ-013 busy  output  1: high while the state is GRANT.

Function
REQ-014 The FSM SHALL have two states: IDLE and GRANT.
REQ-015 In IDLE with any req bit high, the block SHALL select the first requester at or after (last_id+1) mod NREQ, searching upward with wrap-around. It SHALL load owner_id with that index, clear burst_cnt, and enter GRANT next cycle.
REQ-016 In IDLE with req all zero, the state, owner_id and last_id SHALL hold.
REQ-017 accept = (state==GRANT) & req[owner_id] & ~fifo_full, combinational.
REQ-018 fifo_w_en SHALL equal accept. fifo_data_in SHALL equal the owner_id slice of req_data, combinational, with zero added latency.
REQ-019 gnt SHALL be one-hot at owner_id when accept=1, otherwise all zero. gnt SHALL never have more than one bit set.
REQ-020 Each accept SHALL increment burst_cnt, a counter of $clog2(MAX_BURST+1) bits that never wraps.
REQ-021 GRANT SHALL exit to IDLE, with last_id<=owner_id, when either condition holds:
- accept occurs with burst_cnt==MAX_BURST-1;
- req[owner_id]==0.
REQ-022 With fifo_full=1 and req[owner_id]=1, the block SHALL stay in GRANT with burst_cnt held and gnt=0. This is a stall, not a release.
REQ-023 Every tenure change SHALL insert exactly one IDLE cycle, so the worst-case wait for a requester is (NREQ-1)*(MAX_BURST+1) writable cycles.
REQ-024 fifo_w_en SHALL never assert while fifo_full=1 (no overflow).
REQ-025 Requests that arrive mid-tenure SHALL NOT preempt the owner.

Reset
REQ-026 With rst=1 at a posedge, the block SHALL set state=IDLE, burst_cnt=0, owner_id=0 and last_id=NREQ-1, so requester 0 has first priority after reset.
REQ-027 During and after reset, gnt=0, fifo_w_en=0 and busy=0. fifo_data_in SHALL be the slice-0 data (don't-care to the FIFO).
REQ-028 Reset asserted mid-GRANT SHALL abort the tenure within that cycle, with no write issued on the reset cycle.

Structure
REQ-029 The FSM state enum type arb_state_e (IDLE, GRANT) and the default NREQ/MAX_BURST localparams SHALL live in sync_fifo_pkg.
REQ-030 The round-robin priority search SHALL be one sub-module, rr_pick, with inputs req and last_id and outputs found and idx, purely combinational.
REQ-031 The block SHALL instantiate no FIFO. It connects to the existing sync FIFO w_en/data_in/full pins at the top level.

Verification
REQ-032 Reset, then req=4'b0001, data0=0xA1 held -> IDLE one cycle, then 4 writes of 0xA1 with gnt=0001, then an IDLE bubble, then a new tenure for requester 0.
REQ-033 req=4'b1111 held, FIFO never full -> write owners in order 0,1,2,3,0, each tenure exactly 4 writes, one IDLE cycle between tenures.
REQ-034 Owner 2 in GRANT, fifo_full=1 for 3 cycles mid-burst -> gnt=0 and fifo_w_en=0 for those 3 cycles, then the burst resumes with the remaining count unchanged and no owner change.
REQ-035 Owner 1 drops req after 2 writes, req[3]=1 -> return to IDLE, then owner_id=3; requester 2 is skipped because its req=0.
REQ-036 rst pulsed while owner 3 is mid-burst -> no write in the reset cycle; the next tenure goes to requester 0 if req[0]=1.
REQ-037 Every cycle, assertions SHALL check $onehot0(gnt), fifo_w_en==|gnt, and !(fifo_w_en && fifo_full).

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared types and defaults for the sync-FIFO write arbiter block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: arbiter FSM state enum, default sizing localparams and an
// index-width helper. The helper keeps one-requester builds from producing
// zero-width vectors.
package sync_fifo_pkg;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Width of an index into n requesters, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signal bundle of the write arbiter.
// Latency: n/a (wires only).
// Backpressure: fifo_full from the FIFO stalls the accept strobe gnt.
//
// Signals:
//   req          requester write requests, level-held while data is valid
//   req_data     packed requester data, slice i at [i*WIDTH +: WIDTH]
//   gnt          one-hot accept strobe back to the requesters
//   fifo_full    full flag from the shared sync FIFO
//   fifo_w_en    write enable into the FIFO
//   fifo_data_in write data into the FIFO
//   owner_id     index of the current tenure owner
//   busy         arbiter is in a grant tenure
// Modports: master = arbiter side, slave = requesters/FIFO/bench side.
interface fifo_wr_arbiter_if
    import sync_fifo_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int IDW = idx_width(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  fifo_full;
    logic                  fifo_w_en;
    logic [WIDTH-1:0]      fifo_data_in;
    logic [IDW-1:0]        owner_id;
    logic                  busy;

    modport master (
        input  req,
        input  req_data,
        input  fifo_full,
        output gnt,
        output fifo_w_en,
        output fifo_data_in,
        output owner_id,
        output busy
    );

    modport slave (
        output req,
        output req_data,
        output fifo_full,
        input  gnt,
        input  fifo_w_en,
        input  fifo_data_in,
        input  owner_id,
        input  busy
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin pick: first set req bit at or after (last_id+1) mod NREQ, wrapping.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is pending.
//
// Ports:
//   req     request vector
//   last_id index of the previous tenure owner (lowest priority now)
//   found   at least one request is pending
//   idx     chosen requester index (0 when found=0)
module rr_pick
    import sync_fifo_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_id,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    logic [IDW-1:0] cand;

    // Walk the ring from the farthest position back to the nearest so the
    // last hit, which is the one kept, is the closest to last_id+1.
    always_comb begin
        found = |req;
        idx   = '0;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(last_id) + k) % NREQ);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting NREQ writers bursts of up to MAX_BURST writes into one sync FIFO.
// Latency: one IDLE cycle per tenure change; inside a tenure data reaches fifo_data_in combinationally.
// Backpressure: fifo_full stalls the tenure (gnt=0, burst count held) without releasing ownership.
//
// Ports:
//   clk  single clock, posedge
//   rst  synchronous active-high reset; also masks writes in the cycle it is high
//   bus  fifo_wr_arbiter_if master modport (requests, data, FIFO pins, status)
module fifo_wr_arbiter
    import sync_fifo_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                clk,
    input  logic                rst,
    fifo_wr_arbiter_if.master   bus
);

    localparam int IDW = idx_width(NREQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] owner_id_q, owner_id_d;
    logic [IDW-1:0] last_id_q, last_id_d;
    logic [CW-1:0]  burst_cnt_q, burst_cnt_d;

    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic           owner_req;
    logic           accept;
    logic           last_beat;

    logic [WIDTH-1:0] slice_dat [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign slice_dat[i] = bus.req_data[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req     (bus.req),
        .last_id (last_id_q),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    assign owner_req = bus.req[owner_id_q];

    // rst gates the strobe directly so a reset landing mid-tenure issues no
    // write in that same cycle, and fifo_full gates it so the FIFO never overflows.
    assign accept    = !rst && (state_q == GRANT) && owner_req && !bus.fifo_full;
    assign last_beat = accept && (burst_cnt_q == CW'(MAX_BURST - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_id_q  <= '0;
            last_id_q   <= IDW'(NREQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_id_q  <= owner_id_d;
            last_id_q   <= last_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        owner_id_d  = owner_id_q;
        last_id_d   = last_id_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    owner_id_d  = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                // The count stops at MAX_BURST because the tenure ends on that
                // beat, so it cannot wrap.
                if (accept) begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end
                // A full FIFO with the owner still requesting is a stall: stay.
                if (last_beat || !owner_req) begin
                    state_d   = IDLE;
                    last_id_d = owner_id_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.gnt          = accept ? (NREQ'(1) << owner_id_q) : '0;
        bus.fifo_w_en    = accept;
        bus.fifo_data_in = rst ? slice_dat[0] : slice_dat[owner_id_q];
        bus.owner_id     = owner_id_q;
        bus.busy         = !rst && (state_q == GRANT);
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));
    a_wen_gnt:     assert property (@(posedge clk) disable iff (rst) bus.fifo_w_en == (|bus.gnt));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(bus.fifo_w_en && bus.fifo_full));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus hand-written corner sequences.
// Latency: each vector is driven just after a posedge and checked at the following negedge.
// Backpressure: fifo_full is driven per vector to exercise stalls.
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       full;
        logic [3:0] gnt;
        logic       wen;
        logic [7:0] dat;
        logic       busy;
        logic [1:0] owner;
        logic       chk_owner;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic mon_en;
    vec_t vt[$];
    logic [7:0] slc [4];

    fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic f, input logic [3:0] g,
                       input logic w, input logic [7:0] d, input logic b, input logic [1:0] o,
                       input logic co);
        vec_t v;
        v.rst = r; v.req = q; v.full = f; v.gnt = g; v.wen = w;
        v.dat = d; v.busy = b; v.owner = o; v.chk_owner = co;
        vt.push_back(v);
    endtask

    task automatic apply(input string nm, input vec_t v);
        rst           = v.rst;
        bus.req       = v.req;
        bus.fifo_full = v.full;
        @(negedge clk);
        cmp(nm, "gnt",  32'(bus.gnt),          32'(v.gnt));
        cmp(nm, "wen",  32'(bus.fifo_w_en),    32'(v.wen));
        cmp(nm, "data", 32'(bus.fifo_data_in), 32'(v.dat));
        cmp(nm, "busy", 32'(bus.busy),         32'(v.busy));
        if (v.chk_owner) cmp(nm, "owner", 32'(bus.owner_id), 32'(v.owner));
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string nm, input logic r, input logic [3:0] q, input logic f,
                        input logic [3:0] g, input logic w, input logic [7:0] d, input logic b,
                        input logic [1:0] o, input logic co);
        vec_t v;
        v.rst = r; v.req = q; v.full = f; v.gnt = g; v.wen = w;
        v.dat = d; v.busy = b; v.owner = o; v.chk_owner = co;
        apply(nm, v);
    endtask

    // Per-cycle invariants: one-hot gnt, write enable matches gnt, no write into a full FIFO.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (!$onehot0(bus.gnt) || (bus.fifo_w_en !== (|bus.gnt)) || (bus.fifo_w_en && bus.fifo_full)) begin
                n_bad++;
                $display("FAIL invariant @%0t: gnt=%b wen=%b full=%b", $time, bus.gnt, bus.fifo_w_en, bus.fifo_full);
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        mon_en = 1'b0;
        slc[0] = 8'hA1; slc[1] = 8'hB2; slc[2] = 8'hC3; slc[3] = 8'hD4;
        rst           = 1'b1;
        bus.req       = '0;
        bus.fifo_full = 1'b0;
        bus.req_data  = 32'hD4C3B2A1;

        // Single requester 0: reset, IDLE, 4 writes, bubble, new tenure.
        add(1, 4'b0001, 0, 4'b0000, 0, 8'hA1, 0, 2'd0, 0);
        add(1, 4'b0001, 0, 4'b0000, 0, 8'hA1, 0, 2'd0, 1);
        add(0, 4'b0001, 0, 4'b0000, 0, 8'hA1, 0, 2'd0, 1);
        for (int i = 0; i < 4; i++) add(0, 4'b0001, 0, 4'b0001, 1, 8'hA1, 1, 2'd0, 1);
        add(0, 4'b0001, 0, 4'b0000, 0, 8'hA1, 0, 2'd0, 1);
        add(0, 4'b0001, 0, 4'b0001, 1, 8'hA1, 1, 2'd0, 1);
        // Reset during that tenure with everyone requesting: no write this cycle.
        add(1, 4'b1111, 0, 4'b0000, 0, 8'hA1, 0, 2'd0, 1);
        add(0, 4'b1111, 0, 4'b0000, 0, 8'hA1, 0, 2'd0, 1);
        // All requesting: owners 0,1,2,3,0 with four writes each and one IDLE between.
        for (int t = 0; t < 5; t++) begin
            int o;
            o = t % 4;
            for (int i = 0; i < 4; i++)
                add(0, 4'b1111, 0, 4'(1 << o), 1, slc[o], 1, 2'(o), 1);
            add(0, 4'b1111, 0, 4'b0000, 0, slc[o], 0, 2'(o), 1);
        end

        for (int i = 0; i < vt.size(); i++) begin
            apply($sformatf("vec%0d", i), vt[i]);
            if (i == 0) mon_en = 1'b1;
        end

        // Owner 2 stalled by a full FIFO for 3 cycles; a mid-tenure req[0] must not preempt.
        step("stall_rst",   1, 4'b0100, 0, 4'b0000, 0, 8'hA1, 0, 2'd0, 0);
        step("stall_idle",  0, 4'b0100, 0, 4'b0000, 0, 8'hA1, 0, 2'd0, 1);
        step("stall_w1",    0, 4'b0101, 0, 4'b0100, 1, 8'hC3, 1, 2'd2, 1);
        for (int i = 0; i < 3; i++)
            step($sformatf("stall_full%0d", i), 0, 4'b0101, 1, 4'b0000, 0, 8'hC3, 1, 2'd2, 1);
        for (int i = 0; i < 3; i++)
            step($sformatf("stall_w%0d", i + 2), 0, 4'b0101, 0, 4'b0100, 1, 8'hC3, 1, 2'd2, 1);
        step("stall_bubble", 0, 4'b0101, 0, 4'b0000, 0, 8'hC3, 0, 2'd2, 1);
        step("stall_next0",  0, 4'b0101, 0, 4'b0001, 1, 8'hA1, 1, 2'd0, 1);

        // Owner 1 drops after two writes; requester 2 is idle so 3 is next.
        step("drop_rst",   1, 4'b0010, 0, 4'b0000, 0, 8'hA1, 0, 2'd0, 0);
        step("drop_idle",  0, 4'b0010, 0, 4'b0000, 0, 8'hA1, 0, 2'd0, 1);
        step("drop_w1",    0, 4'b1010, 0, 4'b0010, 1, 8'hB2, 1, 2'd1, 1);
        step("drop_w2",    0, 4'b1010, 0, 4'b0010, 1, 8'hB2, 1, 2'd1, 1);
        step("drop_rel",   0, 4'b1000, 0, 4'b0000, 0, 8'hB2, 1, 2'd1, 1);
        step("drop_idle2", 0, 4'b1000, 0, 4'b0000, 0, 8'hB2, 0, 2'd1, 1);
        step("drop_own3",  0, 4'b1000, 0, 4'b1000, 1, 8'hD4, 1, 2'd3, 1);

        // Reset while owner 3 is mid-burst: no write that cycle, requester 0 next.
        step("rst3_cyc",   1, 4'b1001, 0, 4'b0000, 0, 8'hA1, 0, 2'd3, 1);
        step("rst3_idle",  0, 4'b1001, 0, 4'b0000, 0, 8'hA1, 0, 2'd0, 1);
        step("rst3_own0",  0, 4'b1001, 0, 4'b0001, 1, 8'hA1, 1, 2'd0, 1);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
